// File: rtl/esfa_vector_checker.sv
// Vector sequencer: fetches 64-bit vectors from a synchronous ROM, drives the ESFA fields and checks results.
// Optional build macro ESFA_CHECK_CONTINUE_ON_FAIL_EN: keep running after a failed check.
module esfa_vector_checker #(
  parameter int ADDR_W      = 10,
  parameter int ROM_LATENCY = 1,
  parameter int DUT_LATENCY = 1,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [63:0]       rom_data,
  output logic [7:0]        new_index,
  output logic [7:0]        new_value,
  output logic [7:0]        metadata,
  output logic              is_metadata,
  output logic [7:0]        selector,
  input  logic              dut_result_bool,
  input  logic [7:0]        dut_result_value,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              overrun,
  output logic [15:0]       fail_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETTLE, S_CHECK, S_APPLY, S_DONE
  } state_t;

  state_t            state, state_next;
  logic [2:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              exp_bool;
  logic [7:0]        exp_value;
  logic              start_run, fetch_last, settle_last, mismatch, at_top;
  logic              unused_bits;

  assign start_run   = start && (state == S_IDLE || state == S_DONE);
  assign fetch_last  = (state == S_FETCH)  && (int'(wait_cnt) == ROM_LATENCY - 1);
  assign settle_last = (state == S_SETTLE) && (int'(wait_cnt) == DUT_LATENCY - 1);
  assign mismatch    = (dut_result_bool != exp_bool) || (dut_result_value != exp_value);
  assign at_top      = (addr_q == {ADDR_W{1'b1}});
  assign unused_bits = ^{rom_data[63:48], rom_data[7:4]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_next = S_FETCH;
      S_FETCH: begin
        if (fetch_last) begin
          if (rom_data[2])         state_next = S_DONE;
          else if (rom_data[0])    state_next = S_APPLY;
          else if (DUT_LATENCY == 0) state_next = S_CHECK;
          else                     state_next = S_SETTLE;
        end
      end
      S_SETTLE: if (settle_last) state_next = S_CHECK;
      S_CHECK: begin
`ifdef ESFA_CHECK_CONTINUE_ON_FAIL_EN
        state_next = S_APPLY;
`else
        state_next = mismatch ? S_DONE : S_APPLY;
`endif
      end
      S_APPLY: state_next = at_top ? S_DONE : S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_FETCH, S_SETTLE, S_CHECK, S_APPLY: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign pass = (fail_count == 16'd0) && !overrun;

  // The ROM sees the next address a cycle early, so a registered ROM has its
  // word ready after exactly ROM_LATENCY cycles of FETCH.
  always_comb begin
    addr_d = addr_q;
    if (start_run)                          addr_d = '0;
    else if (state == S_APPLY && !at_top)   addr_d = addr_q + 1'b1;
    if (reset)                              addr_d = '0;
  end
  assign rom_addr = addr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q          <= '0;
      wait_cnt        <= '0;
      exp_bool        <= 1'b0;
      exp_value       <= '0;
      new_index       <= '0;
      new_value       <= '0;
      metadata        <= '0;
      is_metadata     <= 1'b0;
      selector        <= '0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      overrun         <= 1'b0;
      cycle_count     <= '0;
    end else begin
      addr_q <= addr_d;

      if (state_next != state) wait_cnt <= '0;
      else                     wait_cnt <= wait_cnt + 3'd1;

      if (fetch_last) begin
        exp_bool  <= rom_data[1];
        exp_value <= rom_data[47:40];
        if (!rom_data[2]) begin
          new_index   <= rom_data[15:8];
          new_value   <= rom_data[23:16];
          metadata    <= rom_data[31:24];
          is_metadata <= rom_data[3];
          selector    <= rom_data[39:32];
        end
      end

      // The clock that accepts start is counted as the run's first clock.
      if (start_run)
        cycle_count <= CNT_W'(1);
      else if (busy && cycle_count != {CNT_W{1'b1}})
        cycle_count <= cycle_count + 1'b1;

      if (start_run) begin
        fail_count      <= '0;
        first_fail_addr <= '0;
        overrun         <= 1'b0;
      end else begin
        if (state == S_CHECK && mismatch) begin
          if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
          if (fail_count == 16'd0)    first_fail_addr <= addr_q;
        end
        if (state == S_APPLY && at_top) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: doc/esfa_vector_checker.md
Name: esfa_vector_checker

Overview:
- Parametrised, self-checking vector sequencer for the ESFA design.
- Fetches 64-bit test vectors from an external synchronous ROM, drives the ESFA input fields, and waits a configurable DUT latency.
- Compares the DUT result against the expected fields and reports pass/fail, fail count, first failing address and cycle count.
- Sits between the block ROM and the ESFADesign instance at the benchmark top level.

Parameters:
- ADDR_W, 10, ROM address width; vector capacity 2^ADDR_W.
- ROM_LATENCY, 1, cycles from rom_addr change to valid rom_data (1..4).
- DUT_LATENCY, 1, cycles from driven fields to valid dut_result_* (0..7).
- CNT_W, 32, width of cycle_count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run from address 0
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  64  vector word
- new_index  out  8  DUT field, vector[15:8]
- new_value  out  8  DUT field, vector[23:16]
- metadata  out  8  DUT field, vector[31:24]
- is_metadata  out  1  DUT field, vector[3]
- selector  out  8  DUT field, vector[39:32]
- dut_result_bool  in  1  DUT boolean result
- dut_result_value  in  8  DUT value result
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- pass  out  1  valid when done=1; 1 = no failures and no overrun
- overrun  out  1  address space exhausted without an end flag
- fail_count  out  16  number of failed check vectors (saturating)
- first_fail_addr  out  ADDR_W  address of the first failing vector
- cycle_count  out  CNT_W  clocks spent busy in the last or current run

Behaviour:
- Vector layout:
  - bit0 = mutate (apply only, no check)
  - bit1 = expected bool
  - bit2 = end of program
  - bit3 = is_metadata
  - [47:40] = expected value
  - other fields as listed under Ports
- Reset values: all outputs 0; pass = 1; first_fail_addr = 0; state IDLE. Reset mid-run aborts immediately to IDLE with these values.
- States:
  - IDLE: rom_addr = 0. start -> FETCH and clears counters, overrun and first_fail_addr.
  - FETCH: hold rom_addr for ROM_LATENCY cycles, then latch rom_data into a vector register.
    - If end flag set -> DONE; fields are not updated.
    - Otherwise drive the DUT fields from the vector; go to APPLY if mutate=1, else SETTLE.
  - SETTLE: wait DUT_LATENCY cycles (0 = skip straight to CHECK).
  - CHECK: fail if dut_result_bool != expected bool OR dut_result_value != expected value (either mismatch fails).
    - On fail: fail_count += 1, saturating at 16'hFFFF. On the first fail only, record rom_addr into first_fail_addr.
    - Without the optional feature, a fail -> DONE; otherwise -> APPLY.
  - APPLY: if rom_addr == 2^ADDR_W-1, set overrun=1 -> DONE; else rom_addr += 1 -> FETCH.
  - DONE: busy=0, done=1, pass = (fail_count==0 && !overrun). start -> FETCH (new run). DUT fields hold their last values.
- Timing: busy=1 from the cycle after start through the last non-DONE cycle. cycle_count increments every busy cycle and saturates at all-ones.
- Edge cases:
  - start while busy: ignored.
  - start in the same cycle as reset: reset wins.
  - DUT fields change only on FETCH completion, so they are stable through SETTLE and CHECK.
- Per-vector latency:
  - mutate vectors: ROM_LATENCY+1 cycles.
  - check vectors: ROM_LATENCY+DUT_LATENCY+2 cycles.

Optional Feature:
- ESFA_CHECK_CONTINUE_ON_FAIL_EN
- Defined: CHECK failures do not stop the run; execution continues to the end flag or overrun, and fail_count accumulates all failures.
- Undefined: the first failure ends the run; fail_count is at most 1.
- first_fail_addr semantics are identical in both builds.

Test Plan:
- ROM = [mutate idx=1 val=5; check exp bool=1 val=5 with DUT returning 1/5; end], ROM_LATENCY=1, DUT_LATENCY=1 -> done=1, pass=1, fail_count=0, cycle_count=8.
- Same ROM but DUT returns value 6 at the check at addr 1 -> done, pass=0, fail_count=1, first_fail_addr=1; DUT returns bool 0 only -> also fails.
- With macro, ROM of 4 check vectors where addrs 1 and 3 mismatch, then end -> fail_count=2, first_fail_addr=1, rom_addr reaches 4.
- ADDR_W=3 ROM with no end flag, all mutate -> overrun=1, pass=0, done after addr 7.
- reset asserted at the third busy cycle -> next cycle busy=0, done=0, pass=1, rom_addr=0; a new start runs normally.
- start pulsed while busy, and start coincident with reset -> no restart or extra run; cycle_count is unaffected.
